// File: rtl/ovl_unchange_checker_if.sv
// Signal bundle between the logic under check and the unchange checker.
// The master side drives the sampled expression and controls; the checker
// (slave side) returns the registered fire vector.
interface ovl_unchange_checker_if #(
    parameter int width = 1
);
    logic             enable;
    logic             start_event;
    logic [width-1:0] test_expr;
    logic [2:0]       fire;

    modport master (
        output enable,
        output start_event,
        output test_expr,
        input  fire
    );

    modport slave (
        input  enable,
        input  start_event,
        input  test_expr,
        output fire
    );
endinterface

// File: rtl/ovl_unchange_checker.sv
// Unchange checker: after a start event, test_expr must hold the captured
// value for num_cks enabled clock edges. fire[0] flags a change, fire[1]
// an illegal new start (action 2), fire[2] a cleanly completed window.
module ovl_unchange_checker #(
    parameter int width               = 1,
    parameter int num_cks             = 1,
    parameter int action_on_new_start = 0,
    parameter     msg                 = "VIOLATION"
) (
    input logic                  clock,
    input logic                  reset,
    ovl_unchange_checker_if.slave chk
);

    localparam int CW = (num_cks < 2) ? 1 : $clog2(num_cks + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(num_cks);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [width-1:0] ref_val;
    logic [2:0]       fire_q;

    assign chk.fire = fire_q;

    // Window tracking, value comparison and registered fire pulses.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            ref_val <= '0;
            fire_q  <= '0;
        end else begin
            fire_q <= '0;
            if (chk.enable) begin
                case (state)
                    IDLE: begin
                        if (chk.start_event) begin
                            ref_val <= chk.test_expr;
                            cnt     <= CNT_LOAD;
                            state   <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (chk.test_expr != ref_val) begin
                            // A mismatch aborts the window; a coincident start is dropped.
                            fire_q[0] <= 1'b1;
                            state     <= IDLE;
`ifdef OVL_ASSERT_ON
                            $error("%s : test_expr changed inside window at time %0t", msg, $time);
`endif
                        end else if (chk.start_event && action_on_new_start == 1) begin
                            // Restart takes priority over completion at the final edge.
                            ref_val <= chk.test_expr;
                            cnt     <= CNT_LOAD;
                        end else begin
                            if (chk.start_event && action_on_new_start == 2) begin
                                fire_q[1] <= 1'b1;
                            end
                            if (cnt == CNT_LAST) begin
                                fire_q[2] <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                cnt <= cnt - CNT_LAST;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ovl_unchange_checker.sv
// Bench for ovl_unchange_checker: three instances with different window
// lengths and restart policies share one stimulus stream. A window model
// based on enabled-edge indices predicts fire every cycle; literal checks
// pin key points of the directed sequence.
module tb_ovl_unchange_checker;

    localparam int N = 3;
    localparam int NCK [N] = '{1, 3, 3};
    localparam int ACT [N] = '{0, 2, 1};

    logic       clock = 1'b0;
    logic       rst   = 1'b0;
    logic       en    = 1'b0;
    logic       st    = 1'b0;
    logic [3:0] ex    = 4'h0;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    ovl_unchange_checker_if #(.width(4)) bus0 ();
    ovl_unchange_checker_if #(.width(4)) bus1 ();
    ovl_unchange_checker_if #(.width(4)) bus2 ();

    assign bus0.enable = en;  assign bus0.start_event = st;  assign bus0.test_expr = ex;
    assign bus1.enable = en;  assign bus1.start_event = st;  assign bus1.test_expr = ex;
    assign bus2.enable = en;  assign bus2.start_event = st;  assign bus2.test_expr = ex;

    ovl_unchange_checker #(.width(4), .num_cks(1), .action_on_new_start(0)) u0 (
        .clock(clock), .reset(rst), .chk(bus0.slave));
    ovl_unchange_checker #(.width(4), .num_cks(3), .action_on_new_start(2)) u1 (
        .clock(clock), .reset(rst), .chk(bus1.slave));
    ovl_unchange_checker #(.width(4), .num_cks(3), .action_on_new_start(1)) u2 (
        .clock(clock), .reset(rst), .chk(bus2.slave));

    logic [2:0] dut_fire [N];
    assign dut_fire[0] = bus0.fire;
    assign dut_fire[1] = bus1.fire;
    assign dut_fire[2] = bus2.fire;

    // Model: a window is identified by the enabled-edge index it opened at;
    // the check edges are the next NCK enabled edges.
    bit         m_open [N];
    int         m_ws   [N];
    int         m_ec   = 0;
    logic [3:0] m_v    [N];
    logic [2:0] m_exp  [N];

    always @(posedge clock) begin
        if (en && rst) m_ec = m_ec + 1;
        for (int i = 0; i < N; i++) begin
            m_exp[i] = 3'b000;
            if (!rst) begin
                m_open[i] = 1'b0;
            end else if (en) begin
                if (!m_open[i]) begin
                    if (st) begin
                        m_open[i] = 1'b1;
                        m_ws[i]   = m_ec;
                        m_v[i]    = ex;
                    end
                end else if (ex != m_v[i]) begin
                    m_exp[i][0] = 1'b1;
                    m_open[i]   = 1'b0;
                end else if (st && ACT[i] == 1) begin
                    m_ws[i] = m_ec;
                    m_v[i]  = ex;
                end else begin
                    if (st && ACT[i] == 2) m_exp[i][1] = 1'b1;
                    if (m_ec - m_ws[i] == NCK[i]) begin
                        m_exp[i][2] = 1'b1;
                        m_open[i]   = 1'b0;
                    end
                end
            end
        end
    end

    // Compare every instance against the model away from the active edge.
    always @(negedge clock) begin
        for (int i = 0; i < N; i++) begin
            vectors = vectors + 1;
            if (dut_fire[i] !== m_exp[i]) begin
                miscompares = miscompares + 1;
                $display("FAIL model u%0d t=%0t: fire=%b expected=%b", i, $time, dut_fire[i], m_exp[i]);
            end
        end
    end

    task automatic lit(input string name, input logic [2:0] got, input logic [2:0] want);
        vectors = vectors + 1;
        if (got !== want) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: fire=%b expected=%b", name, got, want);
        end
    endtask

    // Apply inputs for one edge, return at the following falling edge.
    task automatic cyc(input logic r, input logic e, input logic s, input logic [3:0] x);
        rst = r; en = e; st = s; ex = x;
        @(negedge clock);
    endtask

    initial begin
        // Reset with start/test_expr toggling.
        cyc(0, 1, 1, 4'h3); lit("reset0", bus1.fire, 3'b000);
        cyc(0, 1, 0, 4'hC); lit("reset1", bus0.fire, 3'b000);

        // Stable value, no start.
        cyc(1, 1, 0, 4'h8); cyc(1, 1, 0, 4'h8);
        lit("nostart", bus0.fire, 3'b000);

        // num_cks=1: change after the single check edge is not a violation.
        cyc(1, 1, 1, 4'h4); lit("n1_start", bus0.fire, 3'b000);
        cyc(1, 1, 0, 4'h4); lit("n1_done", bus0.fire, 3'b100);
        cyc(1, 1, 0, 4'hF); lit("n1_after", bus0.fire, 3'b000);

        // num_cks=3: change at the second check edge.
        cyc(1, 1, 1, 4'h5);
        cyc(1, 1, 0, 4'h5); lit("n3_chk1", bus1.fire, 3'b000);
        cyc(1, 1, 0, 4'h6); lit("n3_viol", bus1.fire, 3'b001);
        cyc(1, 1, 0, 4'h6); lit("n3_pulse_end", bus1.fire, 3'b000);
        cyc(1, 1, 0, 4'h6); lit("n3_no_done", bus1.fire, 3'b000);

        // Second start at the first check edge: action 2 flags, action 1 restarts.
        cyc(1, 1, 1, 4'h7);
        cyc(1, 1, 1, 4'h7); lit("a2_newstart", bus1.fire, 3'b010);
        lit("a0_done_at_restart", bus0.fire, 3'b100);
        cyc(1, 1, 0, 4'h7); lit("a2_chk2", bus1.fire, 3'b000);
        cyc(1, 1, 0, 4'h7); lit("a2_done", bus1.fire, 3'b100);
        lit("a1_not_yet", bus2.fire, 3'b000);
        cyc(1, 1, 0, 4'h7); lit("a1_done", bus2.fire, 3'b100);

        // Enable dropped two cycles mid-window while the value changes.
        cyc(1, 1, 1, 4'h9);
        cyc(1, 1, 0, 4'h9);
        cyc(1, 0, 0, 4'h2); lit("pause0", bus1.fire, 3'b000);
        cyc(1, 0, 0, 4'h2); lit("pause1", bus1.fire, 3'b000);
        cyc(1, 1, 0, 4'h9); lit("resume_chk2", bus1.fire, 3'b000);
        cyc(1, 1, 0, 4'h9); lit("resume_done", bus1.fire, 3'b100);

        // Mismatch with a coincident start: start ignored (action 1 instance).
        cyc(1, 1, 1, 4'h1);
        cyc(1, 1, 1, 4'h2); lit("viol_with_start", bus2.fire, 3'b001);
        cyc(1, 1, 0, 4'h3); lit("start_was_dropped", bus2.fire, 3'b000);

        // Reset mid-window discards it.
        cyc(1, 1, 1, 4'hA);
        cyc(1, 1, 0, 4'hA);
        cyc(0, 1, 0, 4'hB); lit("rst_mid", bus1.fire, 3'b000);
        cyc(1, 1, 0, 4'hB); lit("rst_discard", bus1.fire, 3'b000);
        cyc(1, 1, 0, 4'hB);

        // Reset wins over a start at the same edge.
        cyc(0, 1, 1, 4'hD);
        cyc(1, 1, 0, 4'hE); lit("rst_wins", bus2.fire, 3'b000);
        cyc(1, 1, 0, 4'hE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ovl_unchange_checker.md
# ovl_unchange_checker

Synchronous assertion checker that watches a multi-bit expression and flags a violation if it changes value within a fixed window of clock cycles after a start event. It is bound alongside the logic under check in simulation benches, clocked by the bench clock generator, for example 100 MHz. It reports through a registered `fire` vector and has no effect on the checked logic.

## Interface
- `width`, default 1: width of `test_expr`, minimum 1.
- `num_cks`, default 1: window length in cycles, minimum 1.
- `action_on_new_start`, default 0: response to `start_event` while the window is active.
  - 0: ignore.
  - 1: restart the window.
  - 2: report an error.
- `msg`, default "VIOLATION": text for the simulation-only violation message.
- `clock` input, 1 bit: the single clock. Everything samples on its rising edge.
- `reset` input, 1 bit: synchronous, active-low reset. 0 at a rising edge resets the checker.
- `enable` input, 1 bit: gating. While 0 the checker holds all state and does not evaluate.
- `start_event` input, 1 bit: opens a check window when sampled 1.
- `test_expr` input, `width` bits: the expression that must stay unchanged inside the window.
- `fire` output, 3 bits, registered. Each bit is a one-cycle pulse.
  - `fire[0]`: value-change violation.
  - `fire[1]`: illegal new start (only when `action_on_new_start`=2).
  - `fire[2]`: window completed cleanly (coverage).

## Operation
- State:
  - `active` flag.
  - Down-counter `cnt`, sized for `num_cks`.
  - Reference register `ref_val` [`width`-1:0].
- Reset (`reset`=0 at an edge):
  - `active`=0, `cnt`=0, `ref_val`=0, `fire`=3'b000.
  - Reset wins over every other input at that edge.
- `enable`=0 at an edge:
  - State is held and `fire` is 3'b000.
  - A window in progress is paused, not aborted.
- Idle (`active`=0), `enable`=1:
  - If `start_event`=1: `ref_val`<=`test_expr`, `cnt`<=`num_cks`, `active`<=1.
  - Otherwise there is no action.
- Active (`active`=1), `enable`=1, at each edge:
  - Compare `test_expr` to `ref_val`.
  - Mismatch:
    - `fire[0]`<=1.
    - `active`<=0, so the window aborts.
    - Print `msg` plus the time with `$error`. This is simulation only and excluded from synthesis.
    - A `start_event` at the same edge is ignored.
  - Match, `cnt`=1:
    - `fire[2]`<=1 and `active`<=0.
    - Restart handling below still applies.
  - Match, `cnt`>1: `cnt`<=`cnt`-1.
- `start_event`=1 at an edge where `active`=1 and there is no mismatch:
  - Action 0: ignored, including at the final window edge.
  - Action 1: `ref_val`<=`test_expr`, `cnt`<=`num_cks`, `active` stays 1. This overrides completion at the same edge, so `fire[2]` is 0.
  - Action 2: `fire[1]`<=1 and the current window continues unchanged.
- Comparison is exact over all `width` bits. Any bit toggle is a violation.
- Changes outside a window, or while `enable`=0, are never reported.

## Timing
- `start_event` sampled at edge N captures `test_expr` at edge N.
- Check edges are N+1 through N+`num_cks`. Only enabled edges are counted.
- `fire` bits rise one clock after the offending sample.
  - A mismatch sampled at edge N+k drives `fire[0]`=1 from N+k until N+k+1.
- `fire[2]` is high for the single cycle after edge N+`num_cks`.
- Back-to-back windows:
  - A start is accepted at the edge immediately after completion or abort, that is when `active`=0.
  - A start at the completing edge itself follows the restart rules above.
- Reset mid-window discards the window with no `fire` pulse.

## Test plan
- Reset held low for 1 cycle with `start_event` and `test_expr` toggling -> `fire`=000 throughout.
- `enable`=1, `test_expr`=4'b1000 stable for 2 cycles, no start -> `fire`=000.
- `width`=4, `num_cks`=1:
  - `test_expr`=4'b0100, `start_event` pulsed 1 cycle, value held through the next edge, then changed to 4'b1111 -> `fire[0]` never set.
  - `fire[2]` pulses once, one cycle after the check edge.
- `num_cks`=3:
  - Start with `test_expr`=4'h5, change to 4'h6 at the second check edge -> `fire[0]` high for exactly one cycle after that edge.
  - The window closes and no `fire[2]` pulse follows.
- `num_cks`=3, `action_on_new_start`=2:
  - A second start at the first check edge -> `fire[1]` pulse.
  - The original window still completes with `fire[2]` three edges after the first start.
- `enable` dropped for 2 cycles mid-window while `test_expr` changes, restored with the original value -> no `fire[0]`.
  - Completion is delayed by 2 cycles.
